// File: rtl/atmega_tim_prescaler.sv
// Shared timer prescaler and GTCCR controller.
// A free-running 10-bit counter supplies the clk8/64/256/1024 square waves
// that every timer edge-detects. GTCCR.TSM/PSRSYNC reset and hold the counter,
// debug halt freezes it, and the external T pin is synchronised into
// level and edge strobes for the external clock sources.
module atmega_tim_prescaler #(
    parameter int BUS_ADDR_DATA_LEN = 8,
    parameter logic [BUS_ADDR_DATA_LEN-1:0] GTCCR_ADDR = 'h43
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         halt,
    input  logic [BUS_ADDR_DATA_LEN-1:0] addr,
    input  logic                         wr,
    input  logic                         rd,
    input  logic [7:0]                   bus_in,
    output logic [7:0]                   bus_out,
    output logic                         clk8,
    output logic                         clk64,
    output logic                         clk256,
    output logic                         clk1024,
    input  logic                         t,
    output logic                         t_sync,
    output logic                         t_rise,
    output logic                         t_fall
);

    logic [9:0] cnt;
    logic       tsm;
    logic       psrsync;
    logic       gtccr_sel;
    logic       gtccr_wr;
    logic       t_m;
    logic       t_prev;

    assign gtccr_sel = (addr == GTCCR_ADDR);
    assign gtccr_wr  = wr & gtccr_sel;

    // GTCCR bits: a write always wins; otherwise PSRSYNC self-clears unless TSM holds it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            tsm     <= 1'b0;
            psrsync <= 1'b0;
        end else if (gtccr_wr) begin
            tsm     <= bus_in[7];
            psrsync <= bus_in[0];
        end else if (psrsync && !tsm) begin
            psrsync <= 1'b0;
        end
    end

    // Prescaler counter: write-reset, then PSRSYNC hold, then halt freeze, else count (wraps at 10 bits).
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (gtccr_wr && bus_in[0]) begin
            cnt <= '0;
        end else if (psrsync) begin
            cnt <= '0;
        end else if (!halt) begin
            cnt <= cnt + 10'd1;
        end
    end

    // T pin: two-flop synchroniser plus one history flop for edge detection.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            t_m    <= 1'b0;
            t_sync <= 1'b0;
            t_prev <= 1'b0;
        end else begin
            t_m    <= t;
            t_sync <= t_m;
            t_prev <= t_sync;
        end
    end

    assign t_rise = t_sync & ~t_prev;
    assign t_fall = ~t_sync & t_prev;

    // Prescaler taps come straight from counter flops, so they are glitch-free.
    assign clk8    = cnt[2];
    assign clk64   = cnt[5];
    assign clk256  = cnt[7];
    assign clk1024 = cnt[9];

    // Combinational register read; unselected reads return zero.
    always_comb begin
        bus_out = 8'h00;
        if (rd && gtccr_sel) begin
            bus_out = {tsm, 6'b000000, psrsync};
        end
    end

endmodule

// File: tb/tb_atmega_tim_prescaler.sv
// Bench for atmega_tim_prescaler: directed scenarios followed by random
// traffic, all checked against a behavioural model of the prescaler.
module tb_atmega_tim_prescaler;

    logic       clk = 1'b0;
    logic       rst;
    logic       halt;
    logic [7:0] addr;
    logic       wr;
    logic       rd;
    logic [7:0] bus_in;
    logic [7:0] bus_out;
    logic       clk8, clk64, clk256, clk1024;
    logic       t;
    logic       t_sync, t_rise, t_fall;

    int errors = 0;
    int checks = 0;

    // Behavioural model state
    int m_cnt;
    bit m_tsm;
    bit m_psr;
    bit tq[$];   // t as sampled at the most recent edges (oldest first)

    atmega_tim_prescaler #(
        .BUS_ADDR_DATA_LEN(8),
        .GTCCR_ADDR(8'h43)
    ) dut (
        .clk(clk),
        .rst(rst),
        .halt(halt),
        .addr(addr),
        .wr(wr),
        .rd(rd),
        .bus_in(bus_in),
        .bus_out(bus_out),
        .clk8(clk8),
        .clk64(clk64),
        .clk256(clk256),
        .clk1024(clk1024),
        .t(t),
        .t_sync(t_sync),
        .t_rise(t_rise),
        .t_fall(t_fall)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_cnt = 0;
        m_tsm = 1'b0;
        m_psr = 1'b0;
        tq.delete();
    endtask

    // Apply the register rules once per rising edge, using the inputs held at that edge.
    task automatic model_edge();
        bit hit;
        int next_cnt;
        hit = wr && (addr == 8'h43);
        if (hit && bus_in[0])  next_cnt = 0;
        else if (m_psr)        next_cnt = 0;
        else if (halt)         next_cnt = m_cnt;
        else                   next_cnt = (m_cnt + 1) % 1024;
        if (hit) begin
            m_tsm = bus_in[7];
            m_psr = bus_in[0];
        end else begin
            m_psr = m_psr && m_tsm;
        end
        m_cnt = next_cnt;
        tq.push_back(t);
        if (tq.size() > 3) void'(tq.pop_front());
    endtask

    task automatic check_all();
        logic [9:0] c;
        bit ts, tp;
        logic [7:0] eb;
        c  = m_cnt[9:0];
        ts = (tq.size() >= 2) ? tq[tq.size()-2] : 1'b0;
        tp = (tq.size() >= 3) ? tq[tq.size()-3] : 1'b0;
        eb = (rd && addr == 8'h43) ? {m_tsm, 6'b000000, m_psr} : 8'h00;
        chk("cnt", 32'(dut.cnt), 32'(c));
        chk("clkN", 32'({clk1024, clk256, clk64, clk8}), 32'({c[9], c[7], c[5], c[2]}));
        chk("t_sync", 32'(t_sync), 32'(ts));
        chk("t_rise", 32'(t_rise), 32'(ts & ~tp));
        chk("t_fall", 32'(t_fall), 32'(~ts & tp));
        chk("bus_out", 32'(bus_out), 32'(eb));
    endtask

    task automatic step();
        @(posedge clk);
        model_edge();
        #1;
        check_all();
    endtask

    initial begin
        int first8;
        int first1024;
        int rises;
        int rise_at;
        int falls;

        rst = 1'b1; halt = 1'b0; addr = 8'h43; wr = 1'b0; rd = 1'b1; bus_in = 8'h00; t = 1'b0;
        model_reset();
        #2;
        check_all();
        #20 rst = 1'b0;

        // 1. free run from reset
        first8 = -1;
        first1024 = -1;
        for (int i = 1; i <= 1100; i++) begin
            step();
            if (clk8 && first8 < 0) first8 = i;
            if (clk1024 && first1024 < 0) first1024 = i;
        end
        chk("t1_clk8_first_rise", 32'(first8), 32'd4);
        chk("t1_clk1024_first_rise", 32'(first1024), 32'd512);

        // 2. PSRSYNC pulse at cnt=0x155
        for (int g = 0; g < 2048 && m_cnt != 'h155; g++) step();
        chk("t2_reach_155", 32'(dut.cnt), 32'h155);
        wr = 1'b1; bus_in = 8'h01;
        step();
        chk("t2_read_01", 32'(bus_out), 32'h01);
        wr = 1'b0;
        step();
        chk("t2_read_00", 32'(bus_out), 32'h00);
        chk("t2_cnt_held", 32'(dut.cnt), 32'h0);
        step();
        chk("t2_cnt_1", 32'(dut.cnt), 32'h1);

        // 3. TSM hold for 100 cycles, then release
        wr = 1'b1; bus_in = 8'h81;
        step();
        wr = 1'b0;
        repeat (100) step();
        chk("t3_read_81", 32'(bus_out), 32'h81);
        chk("t3_cnt_held", 32'(dut.cnt), 32'h0);
        wr = 1'b1; bus_in = 8'h00;
        step();
        wr = 1'b0;
        step();
        chk("t3_cnt_release", 32'(dut.cnt), 32'h1);

        // 4. halt at 0x20, then PSRSYNC during halt
        for (int g = 0; g < 2048 && m_cnt != 'h20; g++) step();
        halt = 1'b1;
        repeat (10) step();
        chk("t4_halt_cnt", 32'(dut.cnt), 32'h20);
        wr = 1'b1; bus_in = 8'h01;
        step();
        wr = 1'b0;
        step();
        chk("t4_halt_psr_zero", 32'(dut.cnt), 32'h0);
        halt = 1'b0;

        // 5. T pin edges
        rises = 0; rise_at = -1; falls = 0;
        t = 1'b1;
        for (int i = 1; i <= 3; i++) begin
            step();
            if (t_rise) begin rises++; rise_at = i; end
        end
        t = 1'b0;
        for (int i = 1; i <= 4; i++) begin
            step();
            if (t_fall) falls++;
        end
        chk("t5_rise_count", 32'(rises), 32'd1);
        chk("t5_rise_latency", 32'(rise_at), 32'd2);
        chk("t5_fall_count", 32'(falls), 32'd1);

        // 6. async reset during TSM hold
        wr = 1'b1; bus_in = 8'h81; rd = 1'b1; addr = 8'h43;
        step();
        wr = 1'b0;
        repeat (5) step();
        #3 rst = 1'b1;
        #1;
        model_reset();
        check_all();
        chk("t6_read_zero", 32'(bus_out), 32'h00);
        #2 rst = 1'b0;
        step();
        chk("t6_restart", 32'(dut.cnt), 32'h1);

        // random traffic
        repeat (1500) begin
            if ($urandom_range(0, 7) == 0) halt = ~halt;
            wr     = ($urandom_range(0, 15) == 0);
            bus_in = 8'($urandom);
            addr   = ($urandom_range(0, 1) == 1) ? 8'h43 : 8'($urandom);
            rd     = 1'($urandom_range(0, 1));
            if ($urandom_range(0, 3) == 0) t = ~t;
            step();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
